mux_16x1: RTL and testbench
===========================

# mux_16x1

Registered 16-to-1 multiplexer. It selects one of sixteen data lanes with a 4-bit select and presents the chosen lane on a clocked output. It sits in the combinational-blocks library as the wide-select building block, composed from 4-to-1 stages. Default lane width is 1 bit; the lane width is parameterisable.

## Interface
- WIDTH, default 1: bits per data lane and width of `out`.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all registers.
- `in`  input  16*WIDTH  packed data lanes; lane i occupies `in[i*WIDTH +: WIDTH]`; lane 0 is the LSBs.
- `sel`  input  4  lane select, unsigned 0..15.
- `out`  output  WIDTH  selected lane, registered.

## Operation
- Selected value is `in[sel*WIDTH +: WIDTH]`.
- The selection is computed as a two-level tree:
  - Level 1: four 4:1 muxes pick within groups {0-3, 4-7, 8-11, 12-15} using `sel[1:0]`.
  - Level 2: one 4:1 mux picks a group using `sel[3:2]`.
- Every select code 0..15 is valid; there is no illegal or default-to-X case.
- No enable: `out` updates on every clock edge.
- `in` and `sel` are sampled together on the same edge, so a change to either is reflected on the same cycle boundary.
- With WIDTH=1 and `in`=16'hAAAA, even selects yield 0 and odd selects yield 1.

## Timing
- Reset value of `out` is all-zeros. It applies immediately on `rst` assertion, with no clock needed.
- All internal pipeline registers also reset to zero.
- Latency without `MUX16X1_PIPE_EN`:
  - One cycle; `out` after edge k equals the selection of `in`/`sel` sampled at edge k.
  - Throughput is one new selection per cycle.
- Latency with `MUX16X1_PIPE_EN`:
  - Two cycles; one result per cycle.
  - Stage-1 outputs and `sel[3:2]` travel together through the same pipeline register, so there is no select/data skew.
- Reset mid-operation:
  - Any in-flight results are discarded and `out` = 0.
  - The first valid result appears 1 edge after `rst` deasserts without `MUX16X1_PIPE_EN`, or 2 edges after with it. Until then `out` holds 0.
- `rst` deassertion is expected to be synchronised externally. The block adds no synchroniser.

## Configuration
- `MUX16X1_PIPE_EN` defined:
  - A register stage is inserted between level 1 and level 2. The four group results (4×WIDTH bits) and `sel[3:2]` are registered.
  - The level-2 result is then registered into `out`.
  - Total latency is 2 cycles.
- `MUX16X1_PIPE_EN` undefined:
  - Levels 1 and 2 are purely combinational, feeding a single output register.
  - Total latency is 1 cycle.
- The port list is identical in both builds.

## Structure
- Shared package `mux_pkg` holds:
  - `MUX_NUM_INPUTS` = 16
  - `MUX_SEL_W` = 4
  - `MUX_GRP_SEL_W` = 2
  - `MUX_NUM_GROUPS` = 4
- One sub-module, `mux_4x1`:
  - Combinational, parameter WIDTH.
  - Ports `in[4*WIDTH-1:0]`, `sel[1:0]`, `out[WIDTH-1:0]`.
  - Instantiated five times: four at level 1, one at level 2.
- The top level holds only the registers and the instances.

## Test plan
- Reset: assert `rst` with `in`=16'hFFFF, `sel`=4'hF → `out`=0 immediately and stays 0 while `rst`=1.
- Sweep low half: `in`=16'hAAAA, `sel`=0..7 stepped every cycle → after the build latency, `out` sequence is 0,1,0,1,0,1,0,1.
- Full sweep, one-hot: for i=0..15, `in`=1<<i, `sel`=i → `out`=1. Also with `in`=1<<i and `sel`=(i+1)%16 → `out`=0.
- Group boundaries: `in`=16'h8421, `sel` ∈ {0, 5, 10, 15} → `out`=1; `sel` ∈ {3, 4, 11, 12} → `out`=0.
- Latency and skew: alternate `sel` between 4'h0 and 4'hF each cycle with `in`=16'h8000. `out` toggles 0/1, lagging by exactly 1 cycle (or 2 with `MUX16X1_PIPE_EN`).
- Reset mid-stream: during the alternating sweep, pulse `rst` for 1 cycle. `out`=0 at once, and valid output resumes exactly at the latency after deassertion. Run once with WIDTH=8 using lanes 8'h00..8'hFF patterns.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the registered 16-to-1 multiplexer and its 4-to-1 building block.
package mux_pkg;

   localparam int MUX_NUM_INPUTS = 16;
   localparam int MUX_SEL_W      = 4;
   localparam int MUX_GRP_SEL_W  = 2;
   localparam int MUX_NUM_GROUPS = 4;

endpackage

// File: rtl/mux_4x1.sv
// Combinational 4-to-1 lane selector; lane i sits at in[i*WIDTH +: WIDTH].
// Used both to pick within a group of four lanes and to pick among the four groups.
module mux_4x1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [4*WIDTH-1:0]       in,
   input  logic [MUX_GRP_SEL_W-1:0] sel,
   output logic [WIDTH-1:0]         out
);

   // Every select code maps to a real lane, so the default only guards against latches.
   always_comb begin
      out = '0;
      case (sel)
         2'd0: out = in[0*WIDTH +: WIDTH];
         2'd1: out = in[1*WIDTH +: WIDTH];
         2'd2: out = in[2*WIDTH +: WIDTH];
         2'd3: out = in[3*WIDTH +: WIDTH];
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/mux_16x1.sv
// Registered 16-to-1 multiplexer built as a two-level tree of 4-to-1 muxes.
// Optional macro MUX16X1_PIPE_EN inserts a register between the two levels
// (latency 2 instead of 1); the port list is the same in both builds.
module mux_16x1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [MUX_NUM_INPUTS*WIDTH-1:0] in,
   input  logic [MUX_SEL_W-1:0]            sel,
   output logic [WIDTH-1:0]                out
);

   logic [MUX_NUM_GROUPS*WIDTH-1:0] grp_res;
   logic [MUX_NUM_GROUPS*WIDTH-1:0] l2_in;
   logic [MUX_GRP_SEL_W-1:0]        l2_sel;
   logic [WIDTH-1:0]                l2_res;
   logic [WIDTH-1:0]                out_d;
   logic [WIDTH-1:0]                out_q;

   // Level 1: each group of four lanes is narrowed to one lane by the low select bits.
   for (genvar g = 0; g < MUX_NUM_GROUPS; g++) begin : g_level1
      mux_4x1 #(.WIDTH(WIDTH)) u_grp_mux (
         .in  (in[g*4*WIDTH +: 4*WIDTH]),
         .sel (sel[MUX_GRP_SEL_W-1:0]),
         .out (grp_res[g*WIDTH +: WIDTH])
      );
   end

`ifdef MUX16X1_PIPE_EN
   logic [MUX_NUM_GROUPS*WIDTH-1:0] grp_d;
   logic [MUX_NUM_GROUPS*WIDTH-1:0] grp_q;
   logic [MUX_GRP_SEL_W-1:0]        grp_sel_d;
   logic [MUX_GRP_SEL_W-1:0]        grp_sel_q;

   // The group results and the high select bits are captured together so they never skew.
   always_comb begin
      grp_d     = grp_res;
      grp_sel_d = sel[MUX_SEL_W-1:MUX_GRP_SEL_W];
   end

   // Mid-tree pipeline register; cleared on reset so in-flight results are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_q     <= '0;
         grp_sel_q <= '0;
      end else begin
         grp_q     <= grp_d;
         grp_sel_q <= grp_sel_d;
      end
   end

   // Level 2 is fed from the pipeline register.
   always_comb begin
      l2_in  = grp_q;
      l2_sel = grp_sel_q;
   end
`else
   // Level 2 is fed straight from level 1 with the live high select bits.
   always_comb begin
      l2_in  = grp_res;
      l2_sel = sel[MUX_SEL_W-1:MUX_GRP_SEL_W];
   end
`endif

   // Level 2: pick one of the four group results.
   mux_4x1 #(.WIDTH(WIDTH)) u_top_mux (
      .in  (l2_in),
      .sel (l2_sel),
      .out (l2_res)
   );

   // Next value of the output register is simply the tree result.
   always_comb begin
      out_d = l2_res;
   end

   // Output register, updated every edge and cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_mux_16x1.sv
// Directed bench for mux_16x1: a WIDTH=1 instance and a WIDTH=8 instance share
// clock, reset and select. The WIDTH=8 lanes hold the ramp 8'h00,8'h11,..,8'hFF,
// so its expected output for select s is {s,s}.
module tb_mux_16x1;

`ifdef MUX16X1_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  in1;
   logic [127:0] in8;
   logic [3:0]   sel;
   logic         out1;
   logic [7:0]   out8;

   int checks   = 0;
   int failures = 0;

   logic       expQ1[$];
   logic [7:0] expQ8[$];
   string      tagQ[$];

   mux_16x1 #(.WIDTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .in  (in1),
      .sel (sel),
      .out (out1)
   );

   mux_16x1 #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .in  (in8),
      .sel (sel),
      .out (out8)
   );

   always #5 clk = ~clk;

   // Compare both instances' current outputs against the given expectations.
   task automatic checkOutput(input string tag, input logic exp1, input logic [7:0] exp8);
      checks++;
      assert (out1 === exp1) else begin
         failures++;
         $error("[TB] FAIL %s w1: observed=%0h expected=%0h", tag, out1, exp1);
      end
      checks++;
      assert (out8 === exp8) else begin
         failures++;
         $error("[TB] FAIL %s w8: observed=%0h expected=%0h", tag, out8, exp8);
      end
   endtask

   // After reset the pipeline delivers zeros until the first real result emerges.
   task automatic flushModel();
      expQ1.delete();
      expQ8.delete();
      tagQ.delete();
      for (int k = 0; k < LAT - 1; k++) begin
         expQ1.push_back(1'b0);
         expQ8.push_back(8'h00);
         tagQ.push_back("post_reset_zero");
      end
   endtask

   // Drive one vector at a falling edge, clock it, and check the result due LAT vectors back.
   task automatic applyStimulus(input logic [15:0] inVal, input logic [3:0] selVal,
                                input logic exp1, input string tag);
      in1 = inVal;
      sel = selVal;
      expQ1.push_back(exp1);
      expQ8.push_back({selVal, selVal});
      tagQ.push_back(tag);
      @(posedge clk);
      @(negedge clk);
      checkOutput(tagQ[0], expQ1[0], expQ8[0]);
      void'(expQ1.pop_front());
      void'(expQ8.pop_front());
      void'(tagQ.pop_front());
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0;
      in1 = 16'hFFFF;
      sel = 4'hF;
      for (int i = 0; i < 16; i++) begin
         in8[i*8 +: 8] = {i[3:0], i[3:0]};
      end

      // Reset: asynchronous clear, held while rst stays high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("reset_async", 1'b0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_hold1", 1'b0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_hold2", 1'b0, 8'h00);
      rst = 1'b0;
      flushModel();

      // Low-half sweep over 16'hAAAA: even selects give 0, odd give 1.
      applyStimulus(16'hAAAA, 4'd0, 1'b0, "aaaa_s0");
      applyStimulus(16'hAAAA, 4'd1, 1'b1, "aaaa_s1");
      applyStimulus(16'hAAAA, 4'd2, 1'b0, "aaaa_s2");
      applyStimulus(16'hAAAA, 4'd3, 1'b1, "aaaa_s3");
      applyStimulus(16'hAAAA, 4'd4, 1'b0, "aaaa_s4");
      applyStimulus(16'hAAAA, 4'd5, 1'b1, "aaaa_s5");
      applyStimulus(16'hAAAA, 4'd6, 1'b0, "aaaa_s6");
      applyStimulus(16'hAAAA, 4'd7, 1'b1, "aaaa_s7");

      // One-hot sweep: matching select gives 1, the next lane gives 0.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(16'h0001 << i, i[3:0], 1'b1, $sformatf("onehot_hit%0d", i));
         applyStimulus(16'h0001 << i, i[3:0] + 4'd1, 1'b0, $sformatf("onehot_miss%0d", i));
      end

      // Group boundaries with 16'h8421.
      applyStimulus(16'h8421, 4'd0,  1'b1, "grp_s0");
      applyStimulus(16'h8421, 4'd5,  1'b1, "grp_s5");
      applyStimulus(16'h8421, 4'd10, 1'b1, "grp_s10");
      applyStimulus(16'h8421, 4'd15, 1'b1, "grp_s15");
      applyStimulus(16'h8421, 4'd3,  1'b0, "grp_s3");
      applyStimulus(16'h8421, 4'd4,  1'b0, "grp_s4");
      applyStimulus(16'h8421, 4'd11, 1'b0, "grp_s11");
      applyStimulus(16'h8421, 4'd12, 1'b0, "grp_s12");

      // Alternating select with 16'h8000: output toggles with exactly the build latency.
      applyStimulus(16'h8000, 4'h0, 1'b0, "alt0");
      applyStimulus(16'h8000, 4'hF, 1'b1, "alt1");
      applyStimulus(16'h8000, 4'h0, 1'b0, "alt2");
      applyStimulus(16'h8000, 4'hF, 1'b1, "alt3");
      applyStimulus(16'h8000, 4'h0, 1'b0, "alt4");
      applyStimulus(16'h8000, 4'hF, 1'b1, "alt5");
      applyStimulus(16'h8000, 4'hF, 1'b1, "alt6");

      // Mid-stream reset pulse: output clears at once, in-flight data is dropped.
      rst = 1'b1;
      #1;
      checkOutput("midreset_async", 1'b0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_hold", 1'b0, 8'h00);
      rst = 1'b0;
      flushModel();

      applyStimulus(16'h8000, 4'hF, 1'b1, "resume0");
      applyStimulus(16'h8000, 4'h0, 1'b0, "resume1");
      applyStimulus(16'h8000, 4'hF, 1'b1, "resume2");
      applyStimulus(16'h8000, 4'h0, 1'b0, "resume3");
      applyStimulus(16'h8000, 4'hA, 1'b0, "resume4");
      applyStimulus(16'h8000, 4'h5, 1'b0, "resume5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
